// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: burst-limited two-requester arbiter in front of one single-port RAM; define RAM_ARB_FIXED_PRIO_EN to make ties always favour A
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
  localparam logic [7:0] MAXB = 8'(MAX_BURST);
  owner_e owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic last_b_q, last_b_d;
  logic a_rv_q, b_rv_q;
  logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;
  logic cur_req, oth_req, at_max, keep, tie_a, pick_a, any_req, same;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign tie_a = 1'b1;
`else
  assign tie_a = last_b_q;
`endif
  // winner selection, grants, RAM drive and next arbitration state
  always_comb begin
    cur_req  = (owner_q == OWN_A && a_req) || (owner_q == OWN_B && b_req);
    oth_req  = (owner_q == OWN_A && b_req) || (owner_q == OWN_B && a_req);
    at_max   = cnt_q >= MAXB;
    keep     = cur_req && (!at_max || !oth_req);
    pick_a   = keep ? owner_q == OWN_A : (a_req ^ b_req) ? a_req : cur_req ? owner_q == OWN_B : tie_a;
    any_req  = (a_req || b_req) && !rst;
    a_gnt    = any_req && pick_a;
    b_gnt    = any_req && !pick_a;
    ram_we   = a_gnt ? a_we : b_gnt && b_we;
    ram_addr = a_gnt ? a_addr : b_gnt ? b_addr : '0;
    ram_din  = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    same     = (a_gnt && owner_q == OWN_A) || (b_gnt && owner_q == OWN_B);
    owner_d  = a_gnt ? OWN_A : b_gnt ? OWN_B : OWN_NONE;
    cnt_d    = !(a_gnt || b_gnt) ? 8'd0 : !same ? 8'd1 : at_max ? cnt_q : cnt_q + 8'd1;
    last_b_d = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
  end
  // arbitration state register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      cnt_q    <= 8'd0;
      last_b_q <= 1'b1;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end
  // capture read data for granted reads, strobe valid the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rv_q <= a_gnt && !a_we;
      b_rv_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rd_q <= ram_dout;
      if (b_gnt && !b_we) b_rd_q <= ram_dout;
    end
  end
  assign a_rvalid = a_rv_q && !rst;
  assign b_rvalid = b_rv_q && !rst;
  assign a_rdata  = a_rd_q;
  assign b_rdata  = b_rd_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench with a spec-level arbitration/RAM model checked every cycle plus literal scenario pins
module tb_ram_port_arbiter;
  localparam int MAXB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
  logic [31:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [15:0] ram_addr;
  logic [31:0] ram [256];
  logic [31:0] mm [256];
  int checks = 0, errors = 0;
  int m_owner = 0, m_cnt = 0, m_last = 2;
  logic m_arv = 0, m_brv = 0;
  logic [31:0] m_ard = 0, m_brd = 0;
  string seq;

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) begin ram[i] = 0; mm[i] = 0; end
  always @(posedge clk) if (ram_we) ram[ram_addr[7:0]] <= ram_din;
  assign ram_dout = ram[ram_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = no grant, 1 = A, 2 = B, from the winner rule applied to the model state
  function automatic int winner();
    bit cur, oth;
    if (rst || !(a_req || b_req)) return 0;
    cur = (m_owner == 1 && a_req) || (m_owner == 2 && b_req);
    oth = (m_owner == 1 && b_req) || (m_owner == 2 && a_req);
    if (cur && (m_cnt < MAXB || !oth)) return m_owner;
    if (a_req != b_req) return a_req ? 1 : 2;
    if (cur) return 3 - m_owner;
`ifdef RAM_ARB_FIXED_PRIO_EN
    return 1;
`else
    return 3 - m_last;
`endif
  endfunction

  always @(negedge clk) begin
    int w;
    w = winner();
    chk("a_gnt", 64'(a_gnt), 64'(w == 1));
    chk("b_gnt", 64'(b_gnt), 64'(w == 2));
    chk("ram_we", 64'(ram_we), 64'(w == 1 ? a_we : w == 2 ? b_we : 1'b0));
    chk("ram_addr", 64'(ram_addr), 64'(w == 1 ? a_addr : w == 2 ? b_addr : 16'h0));
    chk("ram_din", 64'(ram_din), 64'(w == 1 ? a_wdata : w == 2 ? b_wdata : 32'h0));
    chk("a_rvalid", 64'(a_rvalid), 64'(m_arv && !rst));
    chk("b_rvalid", 64'(b_rvalid), 64'(m_brv && !rst));
    chk("a_rdata", 64'(a_rdata), 64'(m_ard));
    chk("b_rdata", 64'(b_rdata), 64'(m_brd));
    if (rst) begin
      m_owner = 0; m_cnt = 0; m_last = 2;
      m_arv = 0; m_brv = 0; m_ard = 0; m_brd = 0;
    end else begin
      m_arv = w == 1 && !a_we;
      m_brv = w == 2 && !b_we;
      if (m_arv) m_ard = mm[a_addr[7:0]];
      if (m_brv) m_brd = mm[b_addr[7:0]];
      if (w == 1 && a_we) mm[a_addr[7:0]] = a_wdata;
      if (w == 2 && b_we) mm[b_addr[7:0]] = b_wdata;
      if (w == 0) begin
        m_owner = 0; m_cnt = 0;
      end else begin
        m_cnt = (w == m_owner) ? (m_cnt < MAXB ? m_cnt + 1 : m_cnt) : 1;
        m_owner = w; m_last = w;
      end
    end
  end

  task automatic cyc(input logic r, input logic ar, input logic aw, input logic [15:0] aa,
                     input logic [31:0] ad, input logic br, input logic bw,
                     input logic [15:0] ba, input logic [31:0] bd);
    @(posedge clk); #1;
    rst = r; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle(1); idle(1);
    chk("reset_a_rdata", 64'(a_rdata), 64'h0);
    chk("reset_b_rvalid", 64'(b_rvalid), 64'h0);
    // write then read back from A
    cyc(0, 1, 1, 16'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("wr_gnt", 64'(a_gnt), 64'h1);
    chk("wr_ram_we", 64'(ram_we), 64'h1);
    cyc(0, 1, 0, 16'h10, 0, 0, 0, 0, 0);
    chk("rd_gnt", 64'(a_gnt), 64'h1);
    chk("rd_ram_we", 64'(ram_we), 64'h0);
    idle(0);
    chk("rd_rvalid", 64'(a_rvalid), 64'h1);
    chk("rd_rdata", 64'(a_rdata), 64'hDEADBEEF);
    // both requesting continuously from reset
    cyc(1, 1, 0, 16'h10, 0, 1, 0, 16'h11, 0);
    seq = "";
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 16'h10, 0, 1, 0, 16'h11, 0);
      seq = {seq, a_gnt ? "A" : b_gnt ? "B" : "-"};
    end
    checks++;
    if (seq != "AAAABBBBAA") begin
      errors++;
      $display("FAIL grant_seq: got %s expected AAAABBBBAA", seq);
    end
    // tie from idle after A won last
    idle(1); idle(0);
    cyc(0, 1, 0, 16'h10, 0, 0, 0, 0, 0);
    idle(0);
    cyc(0, 1, 0, 16'h10, 0, 1, 0, 16'h10, 0);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("tie_a_first", 64'(a_gnt), 64'h1);
`else
    chk("tie_b_first", 64'(b_gnt), 64'h1);
`endif
    idle(0);
    cyc(0, 0, 0, 0, 0, 1, 1, 16'h20, 32'h12345678);
    chk("b_wr_gnt", 64'(b_gnt), 64'h1);
    // A owner reads twice, then drops; B granted immediately
    idle(1); idle(0);
    cyc(0, 1, 0, 16'h10, 0, 1, 0, 16'h20, 0);
    chk("own_a1", 64'(a_gnt), 64'h1);
    cyc(0, 1, 0, 16'h10, 0, 1, 0, 16'h20, 0);
    chk("own_a2", 64'(a_gnt), 64'h1);
    chk("a_rv1", 64'(a_rvalid), 64'h1);
    cyc(0, 0, 0, 0, 0, 1, 0, 16'h20, 0);
    chk("handover_b", 64'(b_gnt), 64'h1);
    chk("a_rv2", 64'(a_rvalid), 64'h1);
    chk("b_rv_none", 64'(b_rvalid), 64'h0);
    idle(0);
    chk("b_rv", 64'(b_rvalid), 64'h1);
    chk("b_rdata", 64'(b_rdata), 64'h12345678);
    chk("a_rv_off", 64'(a_rvalid), 64'h0);
    // burst counter saturates while the other side is idle, then yields
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 16'(8'h30 + i), 32'(i * 3 + 1), 0, 0, 0, 0);
    chk("long_a", 64'(a_gnt), 64'h1);
    cyc(0, 1, 0, 16'h31, 0, 1, 0, 16'h33, 0);
    chk("yield_b", 64'(b_gnt), 64'h1);
    cyc(0, 1, 0, 16'h31, 0, 0, 0, 0, 0);
    chk("b_rdata_33", 64'(b_rdata), 64'd10);
    idle(0);
    chk("a_rdata_31", 64'(a_rdata), 64'd4);
    // reset right after a granted B read
    cyc(0, 0, 0, 0, 0, 1, 0, 16'h20, 0);
    chk("b_rd_gnt", 64'(b_gnt), 64'h1);
    idle(1);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'h0);
    chk("rst_gnt", 64'(a_gnt | b_gnt), 64'h0);
    cyc(0, 1, 0, 16'h10, 0, 0, 0, 0, 0);
    chk("post_rst_b_rvalid", 64'(b_rvalid), 64'h0);
    chk("post_rst_b_rdata", 64'(b_rdata), 64'h0);
    chk("post_rst_a_gnt", 64'(a_gnt), 64'h1);
    idle(0); idle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
